// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer: three-cycle issue/execute controller for the 8x32 register bank.
// Accepts one instruction in IDLE, reads operands in READ, writes back in WB.
// Optional feature macro: STATUS_FLAGS_EN adds the flags[3:0] = {N,Z,C,V} output.
module reg_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [15:0]       in_instr,
  output logic              in_ready,
  output logic [ADDR_W-1:0] read_reg1,
  output logic [ADDR_W-1:0] read_reg2,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              write_en,
  output logic              done,
  output logic              err
`ifdef STATUS_FLAGS_EN
  ,
  output logic [3:0]        flags
`endif
);

  localparam int SH_W = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WB} state_t;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_OR  = 3, OP_XOR = 4,
    OP_NOT = 5, OP_SLL = 6, OP_SRL = 7, OP_SRA = 8, OP_MOV = 9
  } op_t;

  state_t              state_q, state_d;
  logic [OP_W-1:0]     op_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [ADDR_W-1:0]   rs1_q, rs2_q;
  logic [ADDR_W-1:0]   wreg_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   alu_res;
  logic [SH_W-1:0]     shamt;
  logic                legal;
  logic                unused_instr_bits;

  assign unused_instr_bits = ^in_instr[2:0];

  assign legal      = (op_q <= OP_MOV);
  assign shamt      = read_data2[SH_W-1:0];
  assign read_reg1  = rs1_q;
  assign read_reg2  = rs2_q;
  assign write_reg  = wreg_q;
  assign write_data = wdata_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake/strobe decode; strobes are only live in WB
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    write_en = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_READ;
      end
      S_READ: state_d = S_WB;
      S_WB: begin
        state_d  = S_IDLE;
        write_en = legal && (rd_q != '0);
        done     = legal;
        err      = !legal;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ALU over the operands the bank presents during READ
  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = read_data1 + read_data2;
      OP_SUB:  alu_res = read_data1 - read_data2;
      OP_AND:  alu_res = read_data1 & read_data2;
      OP_OR:   alu_res = read_data1 | read_data2;
      OP_XOR:  alu_res = read_data1 ^ read_data2;
      OP_NOT:  alu_res = ~read_data1;
      OP_SLL:  alu_res = read_data1 << shamt;
      OP_SRL:  alu_res = read_data1 >> shamt;
      OP_SRA:  alu_res = $signed(read_data1) >>> shamt;
      OP_MOV:  alu_res = read_data1;
      default: alu_res = '0;
    endcase
  end

  // Instruction capture on accept; result capture at the end of READ
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (state_q == S_IDLE && in_valid) begin
        op_q  <= in_instr[15:12];
        rd_q  <= in_instr[11:9];
        rs1_q <= in_instr[8:6];
        rs2_q <= in_instr[5:3];
      end
      if (state_q == S_READ) begin
        wreg_q <= rd_q;
        if (legal) wdata_q <= alu_res;
      end
    end
  end

`ifdef STATUS_FLAGS_EN
  logic [3:0] flags_q;
  logic       carry, ovf;

  // Carry/overflow for ADD and SUB only; unsigned carry-out of ADD shows as sum < A
  always_comb begin
    carry = 1'b0;
    ovf   = 1'b0;
    case (op_q)
      OP_ADD: begin
        carry = (alu_res < read_data1);
        ovf   = (read_data1[DATA_W-1] == read_data2[DATA_W-1]) &&
                (alu_res[DATA_W-1] != read_data1[DATA_W-1]);
      end
      OP_SUB: begin
        carry = (read_data1 >= read_data2);
        ovf   = (read_data1[DATA_W-1] != read_data2[DATA_W-1]) &&
                (alu_res[DATA_W-1] != read_data1[DATA_W-1]);
      end
      default: ;
    endcase
  end

  // Flags follow every legal op (including rd==0) and are visible from WB on
  always_ff @(posedge clk) begin
    if (rst)                            flags_q <= '0;
    else if (state_q == S_READ && legal) flags_q <= {alu_res[DATA_W-1], alu_res == '0, carry, ovf};
  end

  assign flags = flags_q;
`endif

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Bench for reg_op_sequencer: behavioural bank plus an arithmetic reference model.
module tb_reg_op_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic [2:0]  read_reg1, read_reg2, write_reg;
  logic [31:0] read_data1, read_data2, write_data;
  logic        write_en, done, err;
`ifdef STATUS_FLAGS_EN
  logic [3:0]  flags;
`endif

  reg_op_sequencer #(.DATA_W(32), .ADDR_W(3), .OP_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2),
    .write_reg(write_reg), .write_data(write_data), .write_en(write_en),
    .done(done), .err(err)
`ifdef STATUS_FLAGS_EN
    , .flags(flags)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] bank   [8];
  logic [31:0] model  [8];
  logic [31:0] ld_vals[8];
  logic        ld = 1'b0;
  int          cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bank read port latches on the falling edge
  always @(negedge clk) begin
    read_data1 <= bank[read_reg1];
    read_data2 <= bank[read_reg2];
  end

  // Bank write port (writes any index, so a stray r0 write is visible) plus bench preload
  always @(posedge clk) begin
    if (ld) for (int i = 0; i < 8; i++) bank[i] <= ld_vals[i];
    else if (write_en) bank[write_reg] <= write_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference ALU: {legal, result}
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    longint      sa;
    sh = b % 32;
    sa = longint'($signed(a));
    case (op)
      4'd0:    return {1'b1, a + b};
      4'd1:    return {1'b1, a - b};
      4'd2:    return {1'b1, a & b};
      4'd3:    return {1'b1, a | b};
      4'd4:    return {1'b1, a ^ b};
      4'd5:    return {1'b1, ~a};
      4'd6:    return {1'b1, a << sh};
      4'd7:    return {1'b1, a >> sh};
      4'd8:    return {1'b1, 32'(sa / (longint'(1) << sh) - ((sa < 0 && (sa % (longint'(1) << sh)) != 0) ? 1 : 0))};
      4'd9:    return {1'b1, a};
      default: return {1'b0, 32'h0};
    endcase
  endfunction

  function automatic logic [15:0] mk(input int op, input int rd, input int rs1, input int rs2);
    return {4'(op), 3'(rd), 3'(rs1), 3'(rs2), 3'b000};
  endfunction

  task automatic load_bank();
    for (int i = 0; i < 8; i++) ld_vals[i] = model[i];
    @(negedge clk);
    ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
  endtask

  // Issue one instruction and check every cycle of its life against the model
  task automatic do_instr(input logic [15:0] ins);
    logic [3:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic [32:0] r;
    int          w;
    op = ins[15:12]; rd = ins[11:9]; rs1 = ins[8:6]; rs2 = ins[5:3];
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 10) begin @(negedge clk); w++; end
    chk("accept_ready", in_ready, 1);
    in_valid = 1'b1;
    in_instr = ins;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("read_ready", in_ready, 0);
    chk("read_rs1", read_reg1, rs1);
    chk("read_rs2", read_reg2, rs2);
    chk("read_we", write_en, 0);
    chk("read_done", done, 0);
    r = ref_alu(op, model[rs1], model[rs2]);
    @(posedge clk); #1;
    chk("wb_we", write_en, r[32] && rd != 0);
    chk("wb_done", done, r[32]);
    chk("wb_err", err, !r[32]);
    chk("wb_ready", in_ready, 0);
    if (r[32]) begin
      chk("wb_data", write_data, r[31:0]);
      chk("wb_reg", write_reg, rd);
      if (rd != 0) model[rd] = r[31:0];
    end
    @(posedge clk); #1;
    chk("post_we", write_en, 0);
    chk("post_done", done, 0);
    chk("post_err", err, 0);
    chk("post_ready", in_ready, 1);
  endtask

  initial begin
    logic [15:0] b2b [4];
    int          acc_cyc [4];
    int          k;
    logic        seen;

    rst = 1'b1; in_valid = 1'b0; in_instr = '0;
    for (int i = 0; i < 8; i++) model[i] = 32'(i);
    load_bank();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", in_ready, 1);
    chk("rst_rr1", read_reg1, 0);
    chk("rst_rr2", read_reg2, 0);
    chk("rst_wreg", write_reg, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_we", write_en, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
`ifdef STATUS_FLAGS_EN
    chk("rst_flags", flags, 0);
`endif

    // Directed cases
    do_instr(mk(0, 3, 1, 2));
    chk("add_r3", bank[3], 32'd3);
    do_instr(mk(1, 4, 1, 2));
    chk("sub_r4", bank[4], 32'hFFFF_FFFF);
`ifdef STATUS_FLAGS_EN
    chk("sub_flags", flags, 4'b1000);
`endif
    model[5] = 32'h8000_0000;
    model[1] = 32'd4;
    load_bank();
    do_instr(mk(8, 5, 5, 1));
    chk("sra_r5", bank[5], 32'hF800_0000);
    do_instr(16'hF000);
    do_instr(mk(0, 0, 1, 2));
    chk("r0_kept", bank[0], 32'd0);

    // in_valid held high across four ADDs; non-accept cycles carry an illegal op
    b2b[0] = mk(0, 1, 1, 2); b2b[1] = mk(0, 2, 2, 3);
    b2b[2] = mk(0, 3, 1, 2); b2b[3] = mk(0, 4, 3, 3);
    k = 0;
    in_instr = 16'hFFFF;
    for (int c = 0; c < 40 && k < 4; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      if (in_ready) begin
        in_instr   = b2b[k];
        acc_cyc[k] = cyc;
        k++;
      end else begin
        in_instr = 16'hFFFF;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_count", k, 4);
    for (int i = 1; i < 4; i++) chk("b2b_gap", acc_cyc[i] - acc_cyc[i-1], 3);
    repeat (3) @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      logic [32:0] r;
      r = ref_alu(b2b[i][15:12], model[b2b[i][8:6]], model[b2b[i][5:3]]);
      model[b2b[i][11:9]] = r[31:0];
    end
    for (int i = 1; i < 5; i++) chk("b2b_bank", bank[i], model[i]);

    // Reset while in READ abandons the instruction
    @(negedge clk);
    in_valid = 1'b1; in_instr = mk(0, 6, 1, 2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rr_in_read", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rr_ready", in_ready, 1);
    chk("rr_we", write_en, 0);
    chk("rr_rr1", read_reg1, 0);
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (write_en) seen = 1'b1; end
    chk("rr_no_write", seen, 0);
    chk("rr_r6", bank[6], model[6]);

    // Randomized instructions against the reference model
    for (int i = 1; i < 8; i++) model[i] = $urandom;
    model[0] = '0;
    load_bank();
    for (int n = 0; n < 40; n++)
      do_instr({4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom)});
    for (int i = 0; i < 8; i++) chk("final_bank", bank[i], model[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
